// File: rtl/draw_req_arbiter.sv
// draw_req_arbiter: round-robin arbiter sharing one rect-draw engine
// request port between NUM_REQ requesters, with optional frame clipping.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   up_base_addr/x/y/w/h/color packed per-requester command slices
//   up_valid / up_ready       per-requester handshake (ready is one-hot)
//   dn_base_addr/x/y/w/h/color registered command to the engine
//   dn_id                     index of the granted requester
//   dn_valid / dn_ready       engine handshake
//   busy                      registered, high whenever not IDLE
//   drop_cnt                  saturating count of clipped-away commands
//
// Build option: define DRAW_ARB_CLIP_EN to enable the bounds drop and
// w/h clamp in the CLIP state; otherwise CLIP is a one-cycle pass-through.

module draw_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int PIX_WIDTH      = 32,
    parameter int IMG_WIDTH      = 1920,
    parameter int IMG_HEIGHT     = 1080,
    parameter int ID_WIDTH       = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] up_base_addr,
    input  logic [NUM_REQ*16-1:0]             up_x,
    input  logic [NUM_REQ*16-1:0]             up_y,
    input  logic [NUM_REQ*16-1:0]             up_w,
    input  logic [NUM_REQ*16-1:0]             up_h,
    input  logic [NUM_REQ*PIX_WIDTH-1:0]      up_color,
    input  logic [NUM_REQ-1:0]                up_valid,
    output logic [NUM_REQ-1:0]                up_ready,
    output logic [AXI_ADDR_WIDTH-1:0]         dn_base_addr,
    output logic [15:0]                       dn_x,
    output logic [15:0]                       dn_y,
    output logic [15:0]                       dn_w,
    output logic [15:0]                       dn_h,
    output logic [PIX_WIDTH-1:0]              dn_color,
    output logic [ID_WIDTH-1:0]               dn_id,
    output logic                              dn_valid,
    input  logic                              dn_ready,
    output logic                              busy,
    output logic [15:0]                       drop_cnt
);

    typedef enum logic [1:0] {IDLE, CLIP, SEND} state_t;

    state_t                    r_state;
    logic [ID_WIDTH-1:0]       r_ptr;
    logic [ID_WIDTH-1:0]       r_id;
    logic [AXI_ADDR_WIDTH-1:0] r_base;
    logic [15:0]               r_x, r_y, r_w, r_h;
    logic [PIX_WIDTH-1:0]      r_color;
    logic                      r_valid;
    logic                      r_busy;

    logic                      w_any;
    logic [ID_WIDTH-1:0]       w_gnt;
    logic [ID_WIDTH-1:0]       w_idx;
    logic [AXI_ADDR_WIDTH-1:0] w_base;
    logic [15:0]               w_x, w_y, w_w, w_h;
    logic [PIX_WIDTH-1:0]      w_color;

    // Walk from the farthest offset down to ptr+1 so the nearest
    // requester after the last winner is the one left in w_gnt.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = ID_WIDTH'((32'(r_ptr) + 32'(k)) % 32'(NUM_REQ));
            if (up_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    always_comb begin
        w_base  = '0;
        w_x     = '0;
        w_y     = '0;
        w_w     = '0;
        w_h     = '0;
        w_color = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt == ID_WIDTH'(i)) begin
                w_base  = up_base_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                w_x     = up_x[i*16 +: 16];
                w_y     = up_y[i*16 +: 16];
                w_w     = up_w[i*16 +: 16];
                w_h     = up_h[i*16 +: 16];
                w_color = up_color[i*PIX_WIDTH +: PIX_WIDTH];
            end
        end
    end

    // Gated by rstn so no requester sees an acceptance that reset discards.
    assign up_ready = (rstn && (r_state == IDLE) && w_any)
                    ? (NUM_REQ'(1) << w_gnt) : '0;

`ifdef DRAW_ARB_CLIP_EN
    logic [15:0] r_drop;
    logic [16:0] w_rem_w, w_rem_h;
    logic        w_drop;
    logic [15:0] w_cw, w_ch;

    // 17-bit so the remaining span never wraps against a 16-bit origin.
    assign w_rem_w = 17'(IMG_WIDTH) - {1'b0, r_x};
    assign w_rem_h = 17'(IMG_HEIGHT) - {1'b0, r_y};
    assign w_drop  = ({1'b0, r_x} >= 17'(IMG_WIDTH))
                  || ({1'b0, r_y} >= 17'(IMG_HEIGHT))
                  || (r_w == 16'd0) || (r_h == 16'd0);
    assign w_cw    = ({1'b0, r_w} > w_rem_w) ? w_rem_w[15:0] : r_w;
    assign w_ch    = ({1'b0, r_h} > w_rem_h) ? w_rem_h[15:0] : r_h;
    assign drop_cnt = r_drop;
`else
    assign drop_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_ptr   <= ID_WIDTH'(NUM_REQ - 1);
            r_id    <= '0;
            r_base  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef DRAW_ARB_CLIP_EN
            r_drop  <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_base  <= w_base;
                        r_x     <= w_x;
                        r_y     <= w_y;
                        r_w     <= w_w;
                        r_h     <= w_h;
                        r_color <= w_color;
                        r_ptr   <= w_gnt;
                        r_id    <= w_gnt;
                        r_state <= CLIP;
                        r_busy  <= 1'b1;
                    end
                end
                CLIP: begin
`ifdef DRAW_ARB_CLIP_EN
                    if (w_drop) begin
                        if (r_drop != 16'hFFFF)
                            r_drop <= r_drop + 16'd1;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_w     <= w_cw;
                        r_h     <= w_ch;
                        r_state <= SEND;
                        r_valid <= 1'b1;
                    end
`else
                    r_state <= SEND;
                    r_valid <= 1'b1;
`endif
                end
                SEND: begin
                    if (dn_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dn_base_addr = r_base;
    assign dn_x         = r_x;
    assign dn_y         = r_y;
    assign dn_w         = r_w;
    assign dn_h         = r_h;
    assign dn_color     = r_color;
    assign dn_id        = r_id;
    assign dn_valid     = r_valid;
    assign busy         = r_busy;

endmodule
